// File: rtl/fuzzy_mmio_pkg.sv
// rtl/fuzzy_mmio_pkg.sv - shared constants, state enum and default thresholds for fuzzy_mmio_regs
//
// Purpose: address map, STATUS/CTRL bit positions, sequencer state encoding
//          and the reset-time trapezoid table used by both register banks.
// Ports:   none (package).

package fuzzy_mmio_pkg;

   localparam logic [7:0] ADDR_STATUS = 8'h00;
   localparam logic [7:0] ADDR_CTRL   = 8'h01;
   localparam logic [7:0] ADDR_IRQ_EN = 8'h02;
   localparam logic [7:0] ADDR_RESULT = 8'h03;
   localparam int         XIN_BASE    = 'h08;
   localparam int         THR_BASE    = 'h10;

   localparam int ST_DONE = 0;
   localparam int ST_BUSY = 1;
   localparam int ST_OVR  = 2;
   localparam int ST_TMO  = 3;

   localparam int CT_START    = 0;
   localparam int CT_REG_MODE = 1;
   localparam int CT_DT_MODE  = 2;
   localparam int CT_INIT     = 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COMMIT = 2'd1,
      S_LAUNCH = 2'd2,
      S_BUSY   = 2'd3
   } state_t;

   // Threshold k (a,b,c,d) of membership set set_idx. The table only makes
   // sense for three 8-bit sets; any other shape starts out all-zero.
   function automatic int default_thr(input int n_sets, input int dw,
                                      input int set_idx, input int k);
      int r;
      r = 0;
      if (n_sets == 3 && dw == 8) begin
         case (set_idx * 4 + k)
            0, 1:    r = -128;
            2:       r = -64;
            4:       r = -64;
            7:       r = 64;
            9:       r = 64;
            10, 11:  r = 127;
            default: r = 0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/fuzzy_mmio_bank.sv
// rtl/fuzzy_mmio_bank.sv - shadow/active register pair with single-cycle commit
//
// Purpose: N entries of DW bits. Bus writes land in the shadow copy; commit
//          copies the whole shadow into the active copy in one cycle.
// Ports:   clk, rst      clock, async active-high reset (both copies <- RST_VAL)
//          wr_en/wr_idx/wr_data  shadow entry write
//          commit        shadow -> active copy
//          shadow        shadow contents (bus readback)
//          active        active contents (drives the core)

module fuzzy_mmio_bank
   import fuzzy_mmio_pkg::*;
#(
   parameter int              DW      = 8,
   parameter int              N       = 1,
   parameter int              IW      = 1,
   parameter logic [N*DW-1:0] RST_VAL = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [IW-1:0]   wr_idx,
   input  logic [DW-1:0]   wr_data,
   input  logic            commit,
   output logic [N*DW-1:0] shadow,
   output logic [N*DW-1:0] active
);

   // Commit reads the shadow before this cycle's write lands, so a write
   // coinciding with commit only reaches the active copy on the next commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= RST_VAL;
         active <= RST_VAL;
      end else begin
         for (int j = 0; j < N; j++) begin
            if (wr_en && wr_idx == IW'(j))
               shadow[j*DW +: DW] <= wr_data;
         end
         if (commit)
            active <= shadow;
      end
   end

endmodule

// File: rtl/fuzzy_mmio_regs.sv
// rtl/fuzzy_mmio_regs.sv - MMIO register file and launch sequencer for a fuzzy inference core
//
// Purpose: byte-addressed register block holding x_in and threshold banks,
//          a START/INIT control register, sticky status flags and the
//          IDLE/COMMIT/LAUNCH/BUSY sequencer that hands a run to the core.
// Ports:   clk, rst                 clock, async active-high reset
//          cs, rd, wr, addr, wdata  bus strobes, byte address, write data
//          rdata                    registered read data (0 when not reading)
//          start, init              one-cycle pulses to the core
//          reg_mode, dt_mode        mode bits
//          x_in, thr                active-bank inputs and thresholds
//          valid, g_in              core result handshake (rising edge) and value
//          irq                      registered interrupt level
// Option:  FUZZY_MMIO_TIMEOUT_EN    adds the BUSY watchdog and the tmo flag

module fuzzy_mmio_regs
   import fuzzy_mmio_pkg::*;
#(
   parameter int DW          = 8,
   parameter int N_IN        = 2,
   parameter int N_SETS      = 3,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cs,
   input  logic                       rd,
   input  logic                       wr,
   input  logic [7:0]                 addr,
   input  logic [DW-1:0]              wdata,
   output logic [DW-1:0]              rdata,
   output logic                       start,
   output logic                       init,
   output logic                       reg_mode,
   output logic                       dt_mode,
   output logic [N_IN*DW-1:0]         x_in,
   output logic [N_IN*N_SETS*4*DW-1:0] thr,
   input  logic                       valid,
   input  logic [DW-1:0]              g_in,
   output logic                       irq
);

   localparam int N_THR = N_IN * N_SETS * 4;
   localparam int XIW   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int TIW   = (N_THR > 1) ? $clog2(N_THR) : 1;

   function automatic logic [N_THR*DW-1:0] thr_defaults();
      logic [N_THR*DW-1:0] v;
      v = '0;
      for (int j = 0; j < N_THR; j++)
         v[j*DW +: DW] = DW'(default_thr(N_SETS, DW, (j / 4) % N_SETS, j % 4));
      return v;
   endfunction

   localparam logic [N_THR*DW-1:0] THR_DEF = thr_defaults();

   state_t               state, state_d;
   logic                 done_q, ovr_q, tmo_q;
   logic                 done_d, ovr_d, tmo_d;
   logic [2:0]           irq_en_q, irq_en_d;
   logic [DW-1:0]        result_q;
   logic                 valid_q;
   logic                 wr_cyc, rd_cyc, st_wr, ctrl_wr;
   logic                 start_cmd, init_cmd, valid_rise;
   logic                 commit, capture, timeout_hit, busy;
   logic                 xin_we, thr_we;
   logic [XIW-1:0]       xin_idx;
   logic [TIW-1:0]       thr_idx;
   logic [N_IN*DW-1:0]   xin_sh;
   logic [N_THR*DW-1:0]  thr_sh;
   logic [DW-1:0]        rd_val;

   assign wr_cyc     = cs && wr;
   assign rd_cyc     = cs && rd;
   assign st_wr      = wr_cyc && (addr == ADDR_STATUS);
   assign ctrl_wr    = wr_cyc && (addr == ADDR_CTRL);
   // INIT takes precedence over START in the same write.
   assign init_cmd   = ctrl_wr && wdata[CT_INIT];
   assign start_cmd  = ctrl_wr && wdata[CT_START] && !wdata[CT_INIT];
   assign valid_rise = valid && !valid_q;
   assign busy       = (state != S_IDLE);

   always_comb begin
      xin_we  = 1'b0;
      xin_idx = '0;
      thr_we  = 1'b0;
      thr_idx = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (addr == 8'(XIN_BASE + i)) begin
            xin_we  = wr_cyc;
            xin_idx = XIW'(i);
         end
      end
      for (int j = 0; j < N_THR; j++) begin
         if (addr == 8'(THR_BASE + j)) begin
            thr_we  = wr_cyc;
            thr_idx = TIW'(j);
         end
      end
   end

   fuzzy_mmio_bank #(.DW(DW), .N(N_IN), .IW(XIW), .RST_VAL('0)) u_xin_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (xin_we),
      .wr_idx  (xin_idx),
      .wr_data (wdata),
      .commit  (commit),
      .shadow  (xin_sh),
      .active  (x_in)
   );

   fuzzy_mmio_bank #(.DW(DW), .N(N_THR), .IW(TIW), .RST_VAL(THR_DEF)) u_thr_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (thr_we),
      .wr_idx  (thr_idx),
      .wr_data (wdata),
      .commit  (commit),
      .shadow  (thr_sh),
      .active  (thr)
   );

   // Sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      commit  = 1'b0;
      capture = 1'b0;
      start   = 1'b0;
      case (state)
         S_IDLE:   if (start_cmd) state_d = S_COMMIT;
         S_COMMIT: begin
            commit  = !init_cmd;
            state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            start   = 1'b1;
            state_d = S_BUSY;
         end
         S_BUSY: begin
            if (valid_rise) begin
               capture = !init_cmd;
               state_d = S_IDLE;
            end else if (timeout_hit) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (init_cmd)
         state_d = S_IDLE;
   end

`ifdef FUZZY_MMIO_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT_CYC + 1);
   logic [TCW-1:0] tmo_cnt;

   // Counts BUSY cycles; cleared in every other state so each run starts at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   tmo_cnt <= '0;
      else if (state != S_BUSY)  tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign timeout_hit = (state == S_BUSY) && (tmo_cnt == TCW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_q <= 1'b0;
      else     tmo_q <= tmo_d;
   end
`else
   logic unused_tmo;
   assign unused_tmo  = ^TIMEOUT_CYC;
   assign timeout_hit = 1'b0;
   assign tmo_q       = 1'b0;
`endif

   // Sticky flags: W1C first, new events win over a same-cycle clear,
   // INIT overrides both.
   always_comb begin
      done_d   = done_q;
      ovr_d    = ovr_q;
      tmo_d    = tmo_q;
      irq_en_d = irq_en_q;
      if (st_wr) begin
         if (wdata[ST_DONE]) done_d = 1'b0;
         if (wdata[ST_OVR])  ovr_d  = 1'b0;
         if (wdata[ST_TMO])  tmo_d  = 1'b0;
      end
      if (capture)              done_d = 1'b1;
      if (start_cmd && busy)    ovr_d  = 1'b1;
      if (timeout_hit && !valid_rise) tmo_d = 1'b1;
      if (init_cmd) begin
         done_d = 1'b0;
         ovr_d  = 1'b0;
         tmo_d  = 1'b0;
      end
      if (wr_cyc && addr == ADDR_IRQ_EN)
         irq_en_d = wdata[2:0];
   end

   always_comb begin
      rd_val = '0;
      if (addr == ADDR_STATUS) begin
         rd_val[ST_DONE] = done_q;
         rd_val[ST_BUSY] = busy;
         rd_val[ST_OVR]  = ovr_q;
         rd_val[ST_TMO]  = tmo_q;
      end else if (addr == ADDR_CTRL) begin
         rd_val[CT_REG_MODE] = reg_mode;
         rd_val[CT_DT_MODE]  = dt_mode;
      end else if (addr == ADDR_IRQ_EN) begin
         rd_val[2:0] = irq_en_q;
      end else if (addr == ADDR_RESULT) begin
         rd_val = result_q;
      end
      for (int i = 0; i < N_IN; i++)
         if (addr == 8'(XIN_BASE + i)) rd_val = xin_sh[i*DW +: DW];
      for (int j = 0; j < N_THR; j++)
         if (addr == 8'(THR_BASE + j)) rd_val = thr_sh[j*DW +: DW];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         irq_en_q <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         reg_mode <= 1'b1;
         dt_mode  <= 1'b1;
         init     <= 1'b0;
         irq      <= 1'b0;
         rdata    <= '0;
      end else begin
         done_q   <= done_d;
         ovr_q    <= ovr_d;
         irq_en_q <= irq_en_d;
         valid_q  <= valid;
         init     <= init_cmd;
         // Built from next-state flags so irq moves on the same edge as STATUS.
         irq      <= |({tmo_d, ovr_d, done_d} & irq_en_d);
         rdata    <= rd_cyc ? rd_val : '0;
         if (capture)
            result_q <= g_in;
         if (ctrl_wr) begin
            reg_mode <= wdata[CT_REG_MODE];
            dt_mode  <= wdata[CT_DT_MODE];
         end
      end
   end

endmodule

// File: tb/tb_fuzzy_mmio_regs.sv
// tb/tb_fuzzy_mmio_regs.sv - self-checking bench for fuzzy_mmio_regs

module tb_fuzzy_mmio_regs;

   localparam int DW          = 8;
   localparam int N_IN        = 2;
   localparam int N_SETS      = 3;
   localparam int TIMEOUT_CYC = 16;
   localparam int N_THR       = N_IN * N_SETS * 4;
   localparam int DEF_TRAP [12] = '{-128, -128, -64, 0, -64, 0, 0, 64, 0, 64, 127, 127};

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  cs = 1'b0, rd = 1'b0, wr = 1'b0, valid = 1'b0;
   logic [7:0]            addr = 8'h00;
   logic [DW-1:0]         wdata = '0, g_in = '0;
   logic [DW-1:0]         rdata;
   logic                  start, init, reg_mode, dt_mode, irq;
   logic [N_IN*DW-1:0]    x_in;
   logic [N_THR*DW-1:0]   thr;

   always #5 clk = ~clk;

   fuzzy_mmio_regs #(.DW(DW), .N_IN(N_IN), .N_SETS(N_SETS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .rd       (rd),
      .wr       (wr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .start    (start),
      .init     (init),
      .reg_mode (reg_mode),
      .dt_mode  (dt_mode),
      .x_in     (x_in),
      .thr      (thr),
      .valid    (valid),
      .g_in     (g_in),
      .irq      (irq)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_run = -1 when idle, otherwise cycles elapsed since START was taken
   // (0 = copy cycle, 1 = start pulse, 2.. = waiting for the core).
   int         m_run;
   bit         m_done, m_ovr, m_tmo, m_reg, m_dt, m_init, m_irq, m_vprev;
   logic [2:0] m_irq_en;
   logic [7:0] m_result, m_rdata;
   logic [7:0] sh_thr [N_THR];
   logic [7:0] ac_thr [N_THR];
   logic [7:0] sh_x   [N_IN];
   logic [7:0] ac_x   [N_IN];

   function automatic logic [7:0] model_read(input logic [7:0] a);
      int ai;
      ai = int'(a);
      if (ai == 0) return {4'b0, m_tmo, m_ovr, (m_run >= 0), m_done};
      if (ai == 1) return {5'b0, m_dt, m_reg, 1'b0};
      if (ai == 2) return {5'b0, m_irq_en};
      if (ai == 3) return m_result;
      if (ai >= 8 && ai < 8 + N_IN) return sh_x[ai - 8];
      if (ai >= 16 && ai < 16 + N_THR) return sh_thr[ai - 16];
      return 8'h00;
   endfunction

   task automatic model_reset();
      m_run = -1;
      m_done = 0; m_ovr = 0; m_tmo = 0;
      m_reg = 1; m_dt = 1;
      m_init = 0; m_irq = 0; m_vprev = 0;
      m_irq_en = '0; m_result = '0; m_rdata = '0;
      for (int j = 0; j < N_THR; j++) begin
         sh_thr[j] = 8'(DEF_TRAP[j % 12]);
         ac_thr[j] = 8'(DEF_TRAP[j % 12]);
      end
      for (int i = 0; i < N_IN; i++) begin
         sh_x[i] = '0;
         ac_x[i] = '0;
      end
   endtask

   task automatic model_step();
      logic [7:0] rv;
      bit wrv, is_init, is_start, rise, set_done, set_ovr, set_tmo;
      int nrun, ai;
      rv       = (cs && rd) ? model_read(addr) : 8'h00;
      wrv      = cs && wr;
      ai       = int'(addr);
      is_init  = wrv && ai == 1 && wdata[3];
      is_start = wrv && ai == 1 && wdata[0] && !wdata[3];
      rise     = valid && !m_vprev;
      set_done = 0; set_ovr = 0; set_tmo = 0;
      nrun     = m_run;
      if (m_run == 0 && !is_init) begin
         for (int j = 0; j < N_THR; j++) ac_thr[j] = sh_thr[j];
         for (int i = 0; i < N_IN; i++)  ac_x[i]   = sh_x[i];
      end
      if (m_run < 0) begin
         if (is_start) nrun = 0;
      end else begin
         if (is_start) set_ovr = 1;
         if (m_run < 2) nrun = m_run + 1;
         else if (rise) begin
            set_done = 1;
            nrun = -1;
            if (!is_init) m_result = g_in;
         end
`ifdef FUZZY_MMIO_TIMEOUT_EN
         else if (m_run - 1 >= TIMEOUT_CYC) begin
            set_tmo = 1;
            nrun = -1;
         end
`endif
         else nrun = m_run + 1;
      end
      if (wrv) begin
         if (ai == 0) begin
            if (wdata[0]) m_done = 0;
            if (wdata[2]) m_ovr  = 0;
            if (wdata[3]) m_tmo  = 0;
         end else if (ai == 1) begin
            m_reg = wdata[1];
            m_dt  = wdata[2];
         end else if (ai == 2) begin
            m_irq_en = wdata[2:0];
         end else if (ai >= 8 && ai < 8 + N_IN) begin
            sh_x[ai - 8] = wdata;
         end else if (ai >= 16 && ai < 16 + N_THR) begin
            sh_thr[ai - 16] = wdata;
         end
      end
      if (set_done) m_done = 1;
      if (set_ovr)  m_ovr  = 1;
      if (set_tmo)  m_tmo  = 1;
      if (is_init) begin
         m_done = 0; m_ovr = 0; m_tmo = 0;
         nrun = -1;
      end
      m_run   = nrun;
      m_init  = is_init;
      m_irq   = |({m_tmo, m_ovr, m_done} & m_irq_en);
      m_rdata = rv;
      m_vprev = valid;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(negedge clk) begin
      logic [N_THR*8-1:0] et;
      logic [N_IN*8-1:0]  ex;
      for (int j = 0; j < N_THR; j++) et[j*8 +: 8] = ac_thr[j];
      for (int i = 0; i < N_IN; i++)  ex[i*8 +: 8] = ac_x[i];
      chk("rdata", rdata, m_rdata);
      chk("start", start, (m_run == 1));
      chk("init", init, m_init);
      chk("irq", irq, m_irq);
      chk("reg_mode", reg_mode, m_reg);
      chk("dt_mode", dt_mode, m_dt);
      chk("x_in", x_in, ex);
      chk("thr", thr, et);
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
      cs = 1; wr = 1; addr = a; wdata = d;
      step();
      cs = 0; wr = 0;
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
      cs = 1; rd = 1; addr = a;
      step();
      cs = 0; rd = 0;
      chk(name, rdata, exp);
   endtask

   initial begin
      step(3);
      rst = 0;

      // Reset contents of the first trapezoid
      chk("thr0_out", thr[31:0], 32'h00C08080);
      rd_chk("rd_0x10", 8'h10, 8'h80);
      rd_chk("rd_0x11", 8'h11, 8'h80);
      rd_chk("rd_0x12", 8'h12, 8'h C0);
      rd_chk("rd_0x13", 8'h13, 8'h00);
      rd_chk("rd_0x27", 8'h27, 8'h7F);
      rd_chk("status_rst", 8'h00, 8'h00);
      rd_chk("ctrl_rst", 8'h01, 8'h06);

      // Shadow write stays invisible until a run commits it
      bus_wr(8'h11, 8'h90);
      chk("thr1_shadow_only", thr[15:8], 8'h80);
      bus_wr(8'h01, 8'h07);
      chk("start_cyc1", start, 1'b0);
      step();
      chk("start_cyc2", start, 1'b1);
      chk("thr1_committed", thr[15:8], 8'h90);
      step();

      // START while busy, then the core answers
      bus_wr(8'h01, 8'h01);
      rd_chk("status_busy_ovr", 8'h00, 8'h06);
      valid = 1; g_in = 8'h42;
      step();
      valid = 0;
      rd_chk("result_42", 8'h03, 8'h42);
      rd_chk("status_done_ovr", 8'h00, 8'h05);

      // Read and clear of done in one cycle returns the old value
      cs = 1; rd = 1; wr = 1; addr = 8'h00; wdata = 8'h01;
      step();
      cs = 0; rd = 0; wr = 0;
      chk("rd_w1c_same_cycle", rdata, 8'h05);
      rd_chk("status_after_w1c", 8'h00, 8'h04);

      // INIT together with START
      bus_wr(8'h01, 8'h09);
      chk("init_pulse", init, 1'b1);
      chk("init_no_start", start, 1'b0);
      rd_chk("status_after_init", 8'h00, 8'h00);

      // Interrupt on done, shadow write colliding with commit
      bus_wr(8'h02, 8'h01);
      bus_wr(8'h09, 8'h7F);
      rd_chk("rd_xin1", 8'h09, 8'h7F);
      chk("xin1_shadow_only", x_in[15:8], 8'h00);
      bus_wr(8'h01, 8'h07);
      bus_wr(8'h10, 8'h11);
      chk("commit_collide_start", start, 1'b1);
      chk("commit_collide_thr0", thr[7:0], 8'h80);
      chk("xin1_committed", x_in[15:8], 8'h7F);
      step();
      valid = 1; g_in = 8'h5A;
      step();
      valid = 0;
      chk("irq_set", irq, 1'b1);
      rd_chk("rd_0x10_shadow", 8'h10, 8'h11);
      rd_chk("result_5a", 8'h03, 8'h5A);
      rd_chk("ctrl_readback", 8'h01, 8'h06);
      bus_wr(8'h00, 8'h01);
      chk("irq_clear", irq, 1'b0);
      rd_chk("status_clear", 8'h00, 8'h00);

      // Unmapped and read-only addresses
      bus_wr(8'h05, 8'hFF);
      rd_chk("rd_unmapped_05", 8'h05, 8'h00);
      rd_chk("rd_unmapped_0a", 8'h0A, 8'h00);
      rd_chk("rd_unmapped_28", 8'h28, 8'h00);
      bus_wr(8'h03, 8'hEE);
      rd_chk("result_ro", 8'h03, 8'h5A);

      // Reset in the middle of a run
      bus_wr(8'h01, 8'h07);
      step(3);
      rst = 1;
      #1;
      chk("rst_start", start, 1'b0);
      chk("rst_init", init, 1'b0);
      chk("rst_reg_mode", reg_mode, 1'b1);
      step(2);
      rst = 0;
      chk("rst_thr1_default", thr[15:8], 8'h80);
      chk("rst_xin", x_in, 16'h0000);
      rd_chk("status_after_rst", 8'h00, 8'h00);
      rd_chk("rd_0x11_after_rst", 8'h11, 8'h80);

      // Core never answers
      bus_wr(8'h01, 8'h01);
      step(20);
`ifdef FUZZY_MMIO_TIMEOUT_EN
      rd_chk("status_timeout", 8'h00, 8'h08);
`else
      rd_chk("status_no_timeout", 8'h00, 8'h02);
`endif
      bus_wr(8'h01, 8'h08);
      rd_chk("status_final", 8'h00, 8'h00);
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fuzzy_mmio_regs.md
FUZZY_MMIO_REGS -- requirements
Module: fuzzy_mmio_regs

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the data and threshold width in bits.
REQ-002 SHALL have parameter N_IN, default 2, meaning the number of fuzzy inputs (T, dT, ...).
REQ-003 SHALL have parameter N_SETS, default 3, meaning the number of membership sets per input, each set holding 4 thresholds a,b,c,d.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the core-response watchdog limit in clk cycles.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, with ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-006 SHALL have bus ports: cs, rd, wr  in  1  bus strobes; addr  in  8  byte address; wdata  in  DW  write data; rdata  out  DW  read data, registered.
REQ-007 SHALL have core ports: start, init  out  1  one-cycle pulses; reg_mode, dt_mode  out  1  mode bits; x_in  out  N_IN*DW  signed inputs; thr  out  N_IN*N_SETS*4*DW  active thresholds; valid  in  1  result ready (level); g_in  in  DW  core result; irq  out  1  interrupt level.

Function
REQ-008 SHALL use this address map: 0x00 STATUS; 0x01 CTRL; 0x02 IRQ_EN; 0x03 RESULT (RO); 0x08+i x_in[i]; 0x10+4*(s+N_SETS*i)+k threshold k of set s of input i. All registers except STATUS and RESULT SHALL be read/write.
REQ-009 SHALL define STATUS as {busy[1], done[0], ovr[2], tmo[3]}; done, ovr and tmo SHALL be sticky and cleared by writing 1 to their bits at 0x00 (W1C); busy SHALL be read-only.
REQ-010 SHALL define CTRL as [0] START (W1P), [1] reg_mode, [2] dt_mode, [3] INIT (W1P); a CTRL read SHALL return 0 in bits 0 and 3.
REQ-011 SHALL land threshold and x_in writes in a shadow bank; the thr and x_in outputs SHALL come only from the active bank.
REQ-012 SHALL implement an FSM with states IDLE, COMMIT, LAUNCH and BUSY.
REQ-013 IDLE SHALL move to COMMIT on START=1.
REQ-014 COMMIT SHALL copy shadow to active in one cycle, then move to LAUNCH.
REQ-015 LAUNCH SHALL drive start=1 for exactly one cycle, then move to BUSY.
REQ-016 BUSY SHALL, on the rising edge of valid, capture g_in into RESULT, set done, and return to IDLE.
REQ-017 Latency from the START write to the start pulse SHALL be exactly 2 cycles.
REQ-018 busy SHALL equal 1 in every state except IDLE.
REQ-019 START in any state other than IDLE SHALL be ignored and SHALL set ovr.
REQ-020 INIT SHALL pulse init for one cycle, force the FSM to IDLE, clear done, ovr and tmo, and leave both banks unchanged; INIT and START in the same write SHALL execute INIT only.
REQ-021 A shadow write in the same cycle as COMMIT SHALL update the shadow only; the active bank SHALL receive the pre-write value.
REQ-022 rdata SHALL be valid one cycle after cs&&rd and SHALL be 0 in every other cycle; an unmapped address SHALL read 0, and a write to it SHALL have no effect.
REQ-023 irq SHALL equal |({tmo,ovr,done} & IRQ_EN[2:0]), registered.
REQ-024 A read and a W1C clear of the same bit in the same cycle SHALL return the pre-clear value.

Reset
REQ-025 While rst is high, the FSM SHALL be IDLE and the outputs SHALL be start=0, init=0, irq=0, rdata=0, reg_mode=1, dt_mode=1.
REQ-026 While rst is high, x_in, RESULT, IRQ_EN and the flags SHALL be 0.
REQ-027 While rst is high, both banks SHALL hold the package default thresholds.
REQ-028 Reset asserted in BUSY SHALL abort with no start or init pulse.

Configuration
REQ-029 With macro FUZZY_MMIO_TIMEOUT_EN defined, a counter SHALL run in BUSY; on reaching TIMEOUT_CYC it SHALL set tmo and return the FSM to IDLE with RESULT unchanged.
REQ-030 Without FUZZY_MMIO_TIMEOUT_EN, the counter SHALL be absent, BUSY SHALL wait indefinitely, and tmo SHALL read 0.

Structure
REQ-031 A package fuzzy_mmio_pkg SHALL hold the address constants, the STATUS/CTRL bit indices, the state enum, and a default-threshold function (trapezoids -128,-128,-64,0 / -64,0,0,64 / 0,64,127,127 for N_SETS=3, DW=8; 0 for all other parameter sets).
REQ-032 A sub-module fuzzy_mmio_bank SHALL implement the parametrised shadow/active register pair with its commit port.

Verification
REQ-033 Reset, then read 0x10..0x13 -> 0x80,0x80,0xC0,0x00; thr_0 equals the same values.
REQ-034 Write 0x11=0x90, then read thr -> unchanged; write CTRL=0x07 -> start pulses at cycle +2 and thr_1 equals 0x90.
REQ-035 In BUSY, write CTRL=0x01 -> no start pulse and STATUS.ovr=1; valid rises with g_in=0x42 -> RESULT=0x42 and done=1.
REQ-036 Set IRQ_EN=0x01, complete a run -> irq=1; write 0x01 to 0x00 -> done=0 and irq=0 on the next cycle.
REQ-037 With FUZZY_MMIO_TIMEOUT_EN and TIMEOUT_CYC=16, hold valid=0 -> FSM returns to IDLE after 16 BUSY cycles with tmo=1.
REQ-038 Write CTRL=0x09 in IDLE -> init pulses, start stays 0, and the flags are cleared.
